// File: rtl/audioport_pkg.sv
// Shared audioport constants and types: I2S word/frame sizes, frame type and
// the transmit controller state encoding.
package audioport_pkg;
  localparam int I2S_DW         = 24;
  localparam int I2S_FRAME_BITS = 2 * I2S_DW;

  typedef logic [1:0][I2S_DW-1:0] audio_frame_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    STOPPING = 2'd2
  } i2s_ctrl_state_t;
endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit clock divider: sck toggles every SCK_HALF clk while enabled and
// emits a one-clk strobe in the cycle whose closing edge drops sck.
module i2s_clkgen #(
  parameter int SCK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic fall_strobe
);
  localparam int CW = $clog2(SCK_HALF);

  logic [CW-1:0] cnt_reg;
  logic          sck_reg;
  logic          wrap;

  assign wrap = en && (cnt_reg == CW'(SCK_HALF - 1));

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg <= '0;
      sck_reg <= 1'b0;
    end else if (wrap) begin
      cnt_reg <= '0;
      sck_reg <= ~sck_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign sck         = sck_reg;
  assign fall_strobe = wrap && sck_reg;
endmodule

// File: rtl/i2s_ctrl.sv
// I2S transmit sequencer: one-frame holding buffer fed by req/ack, 2*DW-bit
// MSB-first serialiser, ws/sck generation. Optional I2S_CTRL_UNDERFLOW_CTR_EN
// adds a saturating underflow counter port.
module i2s_ctrl
  import audioport_pkg::*;
#(
  parameter int SCK_HALF = 4,
  parameter int DW       = I2S_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                play_in,
  input  logic [1:0][DW-1:0]  audio_in,
  input  logic                ack_in,
  output logic                req_out,
  output logic                sck_out,
  output logic                ws_out,
  output logic                sdo_out,
  output logic                underflow_out,
  output logic                busy_out
`ifdef I2S_CTRL_UNDERFLOW_CTR_EN
  ,
  output logic [15:0]         underflow_ctr_out
`endif
);
  localparam int FB = 2 * DW;
  localparam int KW = $clog2(FB);

  i2s_ctrl_state_t state_reg, state_next;

  logic          clk_en, fall, frame_end, load, stop;
  logic [KW-1:0] k_reg, k_next;
  logic          ws_next;
  logic [FB-1:0] frame_in, buf_reg, shift_reg;
  logic          full_reg, sdo_reg, ws_reg, underflow_reg;

  // Left word occupies the upper half so it is shifted out first.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_frame
      assign frame_in[(1-gi)*DW +: DW] = audio_in[gi];
    end
  endgenerate

  i2s_clkgen #(.SCK_HALF(SCK_HALF)) u_clkgen (
    .clk         (clk),
    .rst         (rst),
    .en          (clk_en),
    .sck         (sck_out),
    .fall_strobe (fall)
  );

  assign frame_end = fall && (k_reg == KW'(FB - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (play_in) state_next = PLAY;
      PLAY:     if (!play_in) state_next = STOPPING;
      STOPPING: begin
        if (play_in)        state_next = PLAY;
        else if (frame_end) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    clk_en   = (state_reg != IDLE);
    busy_out = (state_reg != IDLE);
    stop     = frame_end && (state_next == IDLE);
    load     = frame_end && (state_next != IDLE);
  end

  assign k_next  = frame_end ? '0 : k_reg + 1'b1;
  assign ws_next = (k_next >= KW'(DW - 1)) && (k_next <= KW'(FB - 2));

  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg         <= KW'(FB - 1);
      sdo_reg       <= 1'b0;
      ws_reg        <= 1'b0;
      shift_reg     <= '0;
      buf_reg       <= '0;
      full_reg      <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      underflow_reg <= 1'b0;
      if (!clk_en || stop) begin
        k_reg   <= KW'(FB - 1);
        sdo_reg <= 1'b0;
        ws_reg  <= 1'b0;
      end else if (fall) begin
        k_reg  <= k_next;
        ws_reg <= ws_next;
        if (load) begin
          sdo_reg       <= full_reg ? buf_reg[FB-1] : 1'b0;
          shift_reg     <= full_reg ? {buf_reg[FB-2:0], 1'b0} : '0;
          underflow_reg <= !full_reg;
        end else begin
          sdo_reg   <= shift_reg[FB-1];
          shift_reg <= {shift_reg[FB-2:0], 1'b0};
        end
      end
      // An ack can only land while empty, so it never collides with a load of a full buffer.
      if (!full_reg && ack_in) begin
        full_reg <= 1'b1;
        buf_reg  <= frame_in;
      end else if (load) begin
        full_reg <= 1'b0;
      end
    end
  end

  assign req_out       = !full_reg;
  assign sdo_out       = sdo_reg;
  assign ws_out        = ws_reg;
  assign underflow_out = underflow_reg;

`ifdef I2S_CTRL_UNDERFLOW_CTR_EN
  logic [15:0] uf_ctr_reg;

  always_ff @(posedge clk) begin
    if (rst)                                       uf_ctr_reg <= '0;
    else if (underflow_reg && uf_ctr_reg != 16'hFFFF) uf_ctr_reg <= uf_ctr_reg + 16'd1;
  end

  assign underflow_ctr_out = uf_ctr_reg;
`endif
endmodule
